// File: rtl/register_write_scoreboard_if.sv
// rtl/register_write_scoreboard_if.sv - issue/writeback bus and scoreboard status outputs.
interface register_write_scoreboard_if #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  Issue_Valid_i;
  logic [ADDR_WIDTH-1:0] Issue_Rd_i;
  logic [ADDR_WIDTH-1:0] Issue_Rs1_i;
  logic [ADDR_WIDTH-1:0] Issue_Rs2_i;
  logic                  Writeback_Valid_i;
  logic [ADDR_WIDTH-1:0] Writeback_Rd_i;
  logic [NUM_REGS-1:0]   Select_Register_o;
  logic                  Hazard_Rs1_o;
  logic                  Hazard_Rs2_o;
  logic                  Stall_o;
  logic [NUM_REGS-1:0]   Busy_o;
  logic [ADDR_WIDTH:0]   Pending_Count_o;
  logic                  Error_o;

  modport master (
    output Issue_Valid_i, Issue_Rd_i, Issue_Rs1_i, Issue_Rs2_i,
    output Writeback_Valid_i, Writeback_Rd_i,
    input  Select_Register_o, Hazard_Rs1_o, Hazard_Rs2_o, Stall_o,
    input  Busy_o, Pending_Count_o, Error_o
  );

  modport slave (
    input  Issue_Valid_i, Issue_Rd_i, Issue_Rs1_i, Issue_Rs2_i,
    input  Writeback_Valid_i, Writeback_Rd_i,
    output Select_Register_o, Hazard_Rs1_o, Hazard_Rs2_o, Stall_o,
    output Busy_o, Pending_Count_o, Error_o
  );
endinterface

// File: rtl/register_write_scoreboard.sv
// rtl/register_write_scoreboard.sv - register-file write select plus in-flight write scoreboard.
// Optional macro WB_BYPASS_EN: same-cycle writeback releases the register for hazard checks.
module register_write_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  register_write_scoreboard_if.slave   bus
);
  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [NUM_REGS-1:0] busy_q;
  logic [ADDR_WIDTH:0] count_q;
  logic                error_q;

  logic [NUM_REGS-1:0] clear_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] eff_busy;
  logic                rd_ok, rs1_ok, rs2_ok, wb_ok;
  logic                busy_rd, busy_rs1, busy_rs2;
  logic                hazard_rs1, hazard_rs2, waw, stall, accept;
  logic                inc, dec, err_hit;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && ({1'b0, a} < REG_LIMIT);
  endfunction

  assign rd_ok  = addr_ok(bus.Issue_Rd_i);
  assign rs1_ok = addr_ok(bus.Issue_Rs1_i);
  assign rs2_ok = addr_ok(bus.Issue_Rs2_i);
  assign wb_ok  = addr_ok(bus.Writeback_Rd_i);

  always_comb begin
    clear_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (bus.Writeback_Valid_i && wb_ok && !reset && bus.Writeback_Rd_i == ADDR_WIDTH'(i))
        clear_vec[i] = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  assign eff_busy = busy_q & ~clear_vec;
`else
  assign eff_busy = busy_q;
`endif

  // Register 0 and out-of-range addresses never match, so their lookups stay 0.
  always_comb begin
    busy_rd  = 1'b0;
    busy_rs1 = 1'b0;
    busy_rs2 = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (bus.Issue_Rd_i  == ADDR_WIDTH'(i)) busy_rd  = eff_busy[i];
      if (bus.Issue_Rs1_i == ADDR_WIDTH'(i)) busy_rs1 = eff_busy[i];
      if (bus.Issue_Rs2_i == ADDR_WIDTH'(i)) busy_rs2 = eff_busy[i];
    end
  end

  assign hazard_rs1 = bus.Issue_Valid_i & rs1_ok & busy_rs1;
  assign hazard_rs2 = bus.Issue_Valid_i & rs2_ok & busy_rs2;
  assign waw        = rd_ok & busy_rd;
  assign stall      = bus.Issue_Valid_i & (hazard_rs1 | hazard_rs2 | waw) & ~reset;
  assign accept     = bus.Issue_Valid_i & ~stall & ~reset;

  always_comb begin
    set_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (accept && rd_ok && bus.Issue_Rd_i == ADDR_WIDTH'(i))
        set_vec[i] = 1'b1;
    end
  end

  // At most one bit each in set/clear, so the count moves by at most one per direction.
  assign inc     = |(set_vec & ~busy_q);
  assign dec     = |(clear_vec & busy_q & ~set_vec);
  assign err_hit = |(clear_vec & ~busy_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      busy_q <= (busy_q & ~clear_vec) | set_vec;
      if (inc && !dec)
        count_q <= count_q + 1'b1;
      else if (dec && !inc)
        count_q <= count_q - 1'b1;
      if (err_hit)
        error_q <= 1'b1;
    end
  end

  assign bus.Select_Register_o = clear_vec;
  assign bus.Hazard_Rs1_o      = hazard_rs1;
  assign bus.Hazard_Rs2_o      = hazard_rs2;
  assign bus.Stall_o           = stall;
  assign bus.Busy_o            = busy_q;
  assign bus.Pending_Count_o   = count_q;
  assign bus.Error_o           = error_q;
endmodule

// File: tb/tb_register_write_scoreboard.sv
// tb/tb_register_write_scoreboard.sv - directed self-checking bench for register_write_scoreboard.
module tb_register_write_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  register_write_scoreboard_if #(.NUM_REGS(32), .ADDR_WIDTH(5)) a_if ();
  register_write_scoreboard_if #(.NUM_REGS(16), .ADDR_WIDTH(5)) b_if ();

  register_write_scoreboard #(.NUM_REGS(32), .ADDR_WIDTH(5)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave)
  );
  register_write_scoreboard #(.NUM_REGS(16), .ADDR_WIDTH(5)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic iv, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic wv, input logic [4:0] wrd);
    a_if.Issue_Valid_i     = iv;
    a_if.Issue_Rd_i        = rd;
    a_if.Issue_Rs1_i       = rs1;
    a_if.Issue_Rs2_i       = rs2;
    a_if.Writeback_Valid_i = wv;
    a_if.Writeback_Rd_i    = wrd;
  endtask

  task automatic drive_b(input logic iv, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic wv, input logic [4:0] wrd);
    b_if.Issue_Valid_i     = iv;
    b_if.Issue_Rd_i        = rd;
    b_if.Issue_Rs1_i       = rs1;
    b_if.Issue_Rs2_i       = 5'd0;
    b_if.Writeback_Valid_i = wv;
    b_if.Writeback_Rd_i    = wrd;
  endtask

  initial begin
    reset = 1'b1;
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5);
    drive_b(1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_select_forced", 64'(a_if.Select_Register_o), 64'h0);
    chk("reset_busy", 64'(a_if.Busy_o), 64'h0);
    chk("reset_count", 64'(a_if.Pending_Count_o), 64'd0);
    chk("reset_error", 64'(a_if.Error_o), 64'd0);

    // Writeback to an idle register: selects, flags error, busy untouched.
    reset = 1'b0;
    #1;
    chk("wb5_select", 64'(a_if.Select_Register_o), 64'h0000_0020);
    @(negedge clk);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("wb5_error", 64'(a_if.Error_o), 64'd1);
    chk("wb5_busy", 64'(a_if.Busy_o), 64'h0);

    drive_a(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("issue3_stall", 64'(a_if.Stall_o), 64'd0);
    @(negedge clk);
    drive_a(1'b1, 5'd4, 5'd3, 5'd0, 1'b0, 5'd0);
    #1;
    chk("raw_rs1_hazard", 64'(a_if.Hazard_Rs1_o), 64'd1);
    chk("raw_rs1_stall", 64'(a_if.Stall_o), 64'd1);
    chk("issue3_count", 64'(a_if.Pending_Count_o), 64'd1);
    chk("issue3_busy", 64'(a_if.Busy_o), 64'h8);
    @(negedge clk);
    #1;
    chk("stalled_no_set", 64'(a_if.Busy_o), 64'h8);

    drive_a(1'b1, 5'd6, 5'd0, 5'd3, 1'b1, 5'd3);
    #1;
    chk("wb3_select", 64'(a_if.Select_Register_o), 64'h8);
`ifdef WB_BYPASS_EN
    chk("bypass_stall", 64'(a_if.Stall_o), 64'd0);
    @(negedge clk);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("bypass_busy", 64'(a_if.Busy_o), 64'h40);
`else
    chk("nobypass_stall", 64'(a_if.Stall_o), 64'd1);
    chk("nobypass_hazard", 64'(a_if.Hazard_Rs2_o), 64'd1);
    @(negedge clk);
    drive_a(1'b1, 5'd6, 5'd0, 5'd3, 1'b0, 5'd0);
    #1;
    chk("nobypass_cleared", 64'(a_if.Busy_o), 64'h0);
    chk("nobypass_stall_next", 64'(a_if.Stall_o), 64'd0);
    @(negedge clk);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("nobypass_busy", 64'(a_if.Busy_o), 64'h40);
`endif
    chk("rd6_count", 64'(a_if.Pending_Count_o), 64'd1);

    drive_a(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("waw_stall", 64'(a_if.Stall_o), 64'd1);

    drive_a(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0);
    #1;
    chk("reg0_select", 64'(a_if.Select_Register_o), 64'h0);
    chk("reg0_stall", 64'(a_if.Stall_o), 64'd0);
    @(negedge clk);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd6);
    #1;
    chk("reg0_busy", 64'(a_if.Busy_o), 64'h40);
    chk("reg0_count", 64'(a_if.Pending_Count_o), 64'd1);
    @(negedge clk);
    #1;
    chk("wb6_count", 64'(a_if.Pending_Count_o), 64'd0);

    for (int r = 1; r < 32; r++) begin
      drive_a(1'b1, 5'(r), 5'd0, 5'd0, 1'b0, 5'd0);
      @(negedge clk);
    end
    drive_a(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("full_count", 64'(a_if.Pending_Count_o), 64'd31);
    chk("full_busy", 64'(a_if.Busy_o), 64'hFFFF_FFFE);
    chk("full_stall", 64'(a_if.Stall_o), 64'd1);

    reset = 1'b1;
    #1;
    chk("reset_stall_forced", 64'(a_if.Stall_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("midreset_busy", 64'(a_if.Busy_o), 64'h0);
    chk("midreset_count", 64'(a_if.Pending_Count_o), 64'd0);
    chk("midreset_error", 64'(a_if.Error_o), 64'd0);

    // 16-register instance: addresses 16..31 are out of range.
    drive_b(1'b1, 5'd20, 5'd0, 1'b1, 5'd20);
    #1;
    chk("n16_wb20_select", 64'(b_if.Select_Register_o), 64'h0);
    @(negedge clk);
    drive_b(1'b1, 5'd15, 5'd20, 1'b0, 5'd0);
    #1;
    chk("n16_rd20_count", 64'(b_if.Pending_Count_o), 64'd0);
    chk("n16_rs20_hazard", 64'(b_if.Hazard_Rs1_o), 64'd0);
    chk("n16_error", 64'(b_if.Error_o), 64'd0);
    @(negedge clk);
    drive_b(1'b1, 5'd1, 5'd15, 1'b0, 5'd0);
    #1;
    chk("n16_rd15_busy", 64'(b_if.Busy_o), 64'h8000);
    chk("n16_rs15_hazard", 64'(b_if.Hazard_Rs1_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
